// File: rtl/can_pkg.sv
// can_pkg
// Shared CAN definitions: the transmit-side interframe FSM state type,
// bus level constants and the default interframe field lengths.
package can_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME,
        ST_INTERMISSION,
        ST_OVL_FLAG,
        ST_OVL_WAIT,
        ST_OVL_DELIM
    } ifs_tx_state_t;

    localparam logic CAN_DOMINANT  = 1'b0;
    localparam logic CAN_RECESSIVE = 1'b1;

    localparam int DEF_INTERMISSION_BITS = 3;
    localparam int DEF_OVL_FLAG_BITS     = 6;
    localparam int DEF_OVL_DELIM_BITS    = 8;

endpackage

// File: rtl/interframe_tx.sv
// interframe_tx
// Times the intermission after each CAN frame, generates overload frames
// (flag + delimiter) and hands the transmitter its SOF slot.
//
// Ports:
//   clock, nReset    system clock, asynchronous active-low reset
//   samplePoint      one-cycle pulse per bit time, qualifies all bit actions
//   canRX            sampled bus level (0 = dominant)
//   frameEnd         pulse at the end of the last EOF bit, accepted any cycle
//   overloadReq      local receiver asks for an overload delay
//   txPending        a frame is queued for transmission
//   canTX            registered bus drive (1 = recessive)
//   txGrant          pulse: transmitter owns the next bit as SOF
//   rxStart          pulse: SOF of another node detected
//   busIdle          high while in IDLE
//   overloadActive   high during overload flag, wait and delimiter
//   bitError         pulse on flag mismatch, delimiter error or timeout
//
// state           | meaning
// ----------------+-------------------------------------------------------
// ST_IDLE         | bus idle, waiting for local or remote SOF
// ST_FRAME        | a frame is on the bus, waiting for frameEnd
// ST_INTERMISSION | counting intermission bits, watching for overloads
// ST_OVL_FLAG     | driving the dominant overload flag
// ST_OVL_WAIT     | recessive drive, waiting for other nodes' flags to end
// ST_OVL_DELIM    | counting the recessive overload delimiter
module interframe_tx
    import can_pkg::*;
#(
    parameter int INTERMISSION_BITS = DEF_INTERMISSION_BITS,
    parameter int OVL_FLAG_BITS     = DEF_OVL_FLAG_BITS,
    parameter int OVL_DELIM_BITS    = DEF_OVL_DELIM_BITS,
    parameter int MAX_OVERLOADS     = 2,
    parameter int DELIM_TIMEOUT     = 16
) (
    input  logic clock,
    input  logic nReset,
    input  logic samplePoint,
    input  logic canRX,
    input  logic frameEnd,
    input  logic overloadReq,
    input  logic txPending,
    output logic canTX,
    output logic txGrant,
    output logic rxStart,
    output logic busIdle,
    output logic overloadActive,
    output logic bitError
);

    localparam int CW = $clog2(DELIM_TIMEOUT + 1);

    // Counter values at which the corresponding field's last bit is sampled.
    localparam logic [CW-1:0] IFS_LAST   = CW'(INTERMISSION_BITS - 1);
    localparam logic [CW-1:0] FLAG_LAST  = CW'(OVL_FLAG_BITS - 1);
    localparam logic [CW-1:0] DELIM_LAST = CW'(OVL_DELIM_BITS - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(DELIM_TIMEOUT - 1);
    localparam logic [CW-1:0] OVL_MAX    = CW'(MAX_OVERLOADS);

    ifs_tx_state_t state;
    logic [CW-1:0] bitCnt;
    logic [CW-1:0] ovlCount;
    logic          busOvl;
    logic          selfOvl;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == {CW{1'b1}}) ? x : x + 1'b1;
    endfunction

    // Dominant in the first two intermission bits always forces an overload;
    // a local request is honoured only while the consecutive budget lasts.
    assign busOvl  = (canRX == CAN_DOMINANT) && (bitCnt < CW'(2)) && (bitCnt < IFS_LAST);
    assign selfOvl = overloadReq && (ovlCount < OVL_MAX);

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state          <= ST_IDLE;
            bitCnt         <= '0;
            ovlCount       <= '0;
            canTX          <= CAN_RECESSIVE;
            txGrant        <= 1'b0;
            rxStart        <= 1'b0;
            busIdle        <= 1'b1;
            overloadActive <= 1'b0;
            bitError       <= 1'b0;
        end else begin
            txGrant  <= 1'b0;
            rxStart  <= 1'b0;
            bitError <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (samplePoint) begin
                        if (txPending) begin
                            txGrant <= 1'b1;
                            busIdle <= 1'b0;
                            state   <= ST_FRAME;
                        end else if (canRX == CAN_DOMINANT) begin
                            rxStart <= 1'b1;
                            busIdle <= 1'b0;
                            state   <= ST_FRAME;
                        end
                    end
                end
                ST_FRAME: begin
                    // A coincident sample point is not counted as an
                    // elapsed intermission bit.
                    if (frameEnd) begin
                        bitCnt <= '0;
                        state  <= ST_INTERMISSION;
                    end
                end
                ST_INTERMISSION: begin
                    if (samplePoint) begin
                        if (busOvl || selfOvl) begin
                            if (selfOvl) ovlCount <= sat_inc(ovlCount);
                            bitCnt         <= '0;
                            canTX          <= CAN_DOMINANT;
                            overloadActive <= 1'b1;
                            state          <= ST_OVL_FLAG;
                        end else if (bitCnt >= IFS_LAST) begin
                            bitCnt <= '0;
                            if (canRX == CAN_DOMINANT) begin
                                rxStart <= 1'b1;
                                state   <= ST_FRAME;
                            end else if (txPending) begin
                                txGrant  <= 1'b1;
                                ovlCount <= '0;
                                state    <= ST_FRAME;
                            end else begin
                                ovlCount <= '0;
                                busIdle  <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        end else begin
                            bitCnt <= sat_inc(bitCnt);
                        end
                    end
                end
                ST_OVL_FLAG: begin
                    if (samplePoint) begin
                        if (canRX == CAN_RECESSIVE) begin
                            bitError       <= 1'b1;
                            bitCnt         <= '0;
                            ovlCount       <= '0;
                            canTX          <= CAN_RECESSIVE;
                            overloadActive <= 1'b0;
                            busIdle        <= 1'b1;
                            state          <= ST_IDLE;
                        end else if (bitCnt >= FLAG_LAST) begin
                            bitCnt <= '0;
                            canTX  <= CAN_RECESSIVE;
                            state  <= ST_OVL_WAIT;
                        end else begin
                            bitCnt <= sat_inc(bitCnt);
                        end
                    end
                end
                ST_OVL_WAIT: begin
                    if (samplePoint) begin
                        if (canRX == CAN_RECESSIVE) begin
                            // This recessive bit is the first delimiter bit.
                            bitCnt <= CW'(1);
                            state  <= ST_OVL_DELIM;
                        end else if (bitCnt >= WAIT_LAST) begin
                            bitError       <= 1'b1;
                            bitCnt         <= '0;
                            ovlCount       <= '0;
                            overloadActive <= 1'b0;
                            busIdle        <= 1'b1;
                            state          <= ST_IDLE;
                        end else begin
                            bitCnt <= sat_inc(bitCnt);
                        end
                    end
                end
                ST_OVL_DELIM: begin
                    if (samplePoint) begin
                        if (canRX == CAN_DOMINANT) begin
                            bitError       <= 1'b1;
                            bitCnt         <= '0;
                            ovlCount       <= '0;
                            overloadActive <= 1'b0;
                            busIdle        <= 1'b1;
                            state          <= ST_IDLE;
                        end else if (bitCnt >= DELIM_LAST) begin
                            bitCnt         <= '0;
                            overloadActive <= 1'b0;
                            state          <= ST_INTERMISSION;
                        end else begin
                            bitCnt <= sat_inc(bitCnt);
                        end
                    end
                end
                default: begin
                    bitCnt         <= '0;
                    canTX          <= CAN_RECESSIVE;
                    overloadActive <= 1'b0;
                    busIdle        <= 1'b1;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interframe_tx.sv
// tb_interframe_tx
// Directed, table-driven bench for interframe_tx. The bus is modelled as a
// wired-AND of the DUT drive and one other node ("other").
// Output vectors are packed as {canTX, txGrant, rxStart, busIdle,
// overloadActive, bitError}.
module tb_interframe_tx;

    logic clock;
    logic nReset;
    logic samplePoint;
    logic canRX;
    logic frameEnd;
    logic overloadReq;
    logic txPending;
    logic canTX;
    logic txGrant;
    logic rxStart;
    logic busIdle;
    logic overloadActive;
    logic bitError;
    logic other;

    int n_vec = 0;
    int n_bad = 0;

    assign canRX = canTX & other;

    interframe_tx dut (
        .clock         (clock),
        .nReset        (nReset),
        .samplePoint   (samplePoint),
        .canRX         (canRX),
        .frameEnd      (frameEnd),
        .overloadReq   (overloadReq),
        .txPending     (txPending),
        .canTX         (canTX),
        .txGrant       (txGrant),
        .rxStart       (rxStart),
        .busIdle       (busIdle),
        .overloadActive(overloadActive),
        .bitError      (bitError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       fe;
        logic       fe_sp;
        logic       oth;
        logic       txp;
        logic       ovr;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fe, input logic fe_sp, input logic oth,
                                input logic txp, input logic ovr, input logic [5:0] e);
        vec_t r;
        r.fe = fe; r.fe_sp = fe_sp; r.oth = oth; r.txp = txp; r.ovr = ovr; r.exp = e;
        return r;
    endfunction

    function automatic logic [5:0] outs();
        return {canTX, txGrant, rxStart, busIdle, overloadActive, bitError};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (canTX,txGrant,rxStart,busIdle,ovlAct,bitError)",
                     name, got, exp);
        end
    endtask

    task automatic pulse_fe();
        @(negedge clock) frameEnd = 1'b1;
        @(negedge clock) frameEnd = 1'b0;
    endtask

    // One bit time: sample point in the first cycle, outputs captured in the
    // cycle after the deciding edge, then two quiet cycles.
    task automatic apply_bit(input logic oth, input logic txp, input logic ovr,
                             input logic fe_sp, output logic [5:0] got);
        @(negedge clock);
        other       = oth;
        txPending   = txp;
        overloadReq = ovr;
        samplePoint = 1'b1;
        frameEnd    = fe_sp;
        @(negedge clock);
        samplePoint = 1'b0;
        frameEnd    = 1'b0;
        got = outs();
        @(negedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] got;
        int ovl_frames;

        nReset = 1'b0; samplePoint = 1'b0; frameEnd = 1'b0;
        overloadReq = 1'b0; txPending = 1'b0; other = 1'b1;

        // Grant, then a plain intermission to IDLE.
        vecs.push_back(mk(0,0,1,1,0, 6'b110000));
        vecs.push_back(mk(1,0,1,0,0, 6'b100000));
        vecs.push_back(mk(0,0,1,0,0, 6'b100000));
        vecs.push_back(mk(0,0,1,0,0, 6'b100100));
        // Remote SOF from IDLE, then dominant at intermission bit 1.
        vecs.push_back(mk(0,0,0,0,0, 6'b101000));
        vecs.push_back(mk(1,0,1,0,0, 6'b100000));
        vecs.push_back(mk(0,0,0,0,0, 6'b000010));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,0,0, 6'b000010));
        vecs.push_back(mk(0,0,0,0,0, 6'b100010));
        // First recessive bit plus seven more delimiter bits.
        for (int i = 0; i < 7; i++) vecs.push_back(mk(0,0,1,0,0, 6'b100010));
        vecs.push_back(mk(0,0,1,0,0, 6'b100000));
        // New intermission ending with a grant.
        vecs.push_back(mk(0,0,1,0,0, 6'b100000));
        vecs.push_back(mk(0,0,1,0,0, 6'b100000));
        vecs.push_back(mk(0,0,1,1,0, 6'b110000));
        // Dominant on the last intermission bit beats txPending.
        vecs.push_back(mk(1,0,1,0,0, 6'b100000));
        vecs.push_back(mk(0,0,1,0,0, 6'b100000));
        vecs.push_back(mk(0,0,0,1,0, 6'b101000));
        // frameEnd coincident with a sample point: still three bits to IDLE.
        vecs.push_back(mk(0,1,1,0,0, 6'b100000));
        vecs.push_back(mk(0,0,1,0,0, 6'b100000));
        vecs.push_back(mk(0,0,1,0,0, 6'b100000));
        vecs.push_back(mk(0,0,1,0,0, 6'b100100));

        repeat (3) @(negedge clock);
        check("reset_state", outs(), 6'b100100);
        nReset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].fe) pulse_fe();
            apply_bit(vecs[i].oth, vecs[i].txp, vecs[i].ovr, vecs[i].fe_sp, got);
            check($sformatf("vec%0d", i), got, vecs[i].exp);
            if (i == 0) check("grant_single_pulse", outs(), 6'b100000);
        end

        // overloadReq held across three intermissions, txPending high.
        apply_bit(1, 1, 0, 0, got);
        check("ovl_seq_grant", got, 6'b110000);
        pulse_fe();
        ovl_frames = 0;
        for (int it = 0; it < 3; it++) begin
            apply_bit(1, 1, 1, 0, got);
            if (got[1]) ovl_frames++;
            check($sformatf("ovl_seq_it%0d_bit0", it), got, (it < 2) ? 6'b000010 : 6'b100000);
            if (it < 2) begin
                repeat (14) apply_bit(1, 1, 1, 0, got);
                check($sformatf("ovl_seq_it%0d_back", it), got, 6'b100000);
            end
        end
        apply_bit(1, 1, 1, 0, got);
        check("ovl_seq_it2_bit1", got, 6'b100000);
        apply_bit(1, 1, 1, 0, got);
        check("ovl_seq_it2_grant", got, 6'b110000);
        check("ovl_frame_count", 6'(ovl_frames), 6'd2);
        overloadReq = 1'b0;

        // Delimiter timeout: dominant held for DELIM_TIMEOUT bits in OVL_WAIT.
        pulse_fe();
        apply_bit(0, 0, 0, 0, got);
        check("tmo_enter", got, 6'b000010);
        repeat (5) apply_bit(0, 0, 0, 0, got);
        apply_bit(0, 0, 0, 0, got);
        check("tmo_wait_entry", got, 6'b100010);
        for (int i = 1; i <= 16; i++) begin
            apply_bit(0, 0, 0, 0, got);
            check($sformatf("tmo_bit%0d", i), got, (i < 16) ? 6'b100010 : 6'b100101);
        end
        check("tmo_err_cleared", outs(), 6'b100100);

        // Asynchronous reset during the overload flag.
        apply_bit(0, 0, 0, 0, got);
        check("rst_rx_sof", got, 6'b101000);
        pulse_fe();
        apply_bit(0, 0, 0, 0, got);
        check("rst_ovl_enter", got, 6'b000010);
        repeat (3) apply_bit(0, 0, 0, 0, got);
        check("rst_flag_bit3", got, 6'b000010);
        @(negedge clock);
        #2 nReset = 1'b0;
        #1 check("rst_async", outs(), 6'b100100);
        @(negedge clock);
        check("rst_held", outs(), 6'b100100);
        nReset = 1'b1;
        other  = 1'b1;
        apply_bit(1, 0, 0, 0, got);
        check("rst_after_idle", got, 6'b100100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
